digit_frame_latch: RTL and testbench
====================================

// Module: digit_frame_latch
// PURPOSE
//  Display-data staging stage that feeds the VGA image/text overlay (digit nibbles dig0..dig17, dato0, dato2, crontermino).
//  Accepts byte writes from the RTC/chronometer controller into a shadow bank over a valid/ready port.
//  Commits the shadow bank to the display bank once per frame, on the vsync falling edge, so the raster never shows a half-updated time.
//  Also produces the blinking ring indication and sticky error flags.
// PARAMETERS
//  BLINK_FRAMES  30  frames per ring blink half-period (1..255)
//  SYNC_STAGES   2   vsync synchroniser depth (>=2)
// PORTS
//  clk           in   1   system clock (one clock domain; vsync_i is resynchronised to it)
//  reset_i       in   1   asynchronous, active-high reset
//  vsync_i       in   1   vsync from vgasync, active low
//  wr_valid_i    in   1   write request
//  wr_ready_o    out  1   write accepted when valid&ready
//  wr_addr_i     in   4   0..8 = BCD byte, 9 = control, 15 = clear errors
//  wr_data_i     in   8   write data
//  dig0_o..dig17_o out 4 each  committed BCD nibbles
//  dato0_o       out  8   8'h01 = 12 h format, else 8'h00
//  dato2_o       out  8   8'h01 = AM, 8'h00 = PM
//  crontermino_o out  1   blinking ring request
//  frame_tick_o  out  1   one-cycle pulse on each commit
//  bcd_err_o     out  1   sticky: a nibble > 9 was written
//  addr_err_o    out  1   sticky: an address in 10..14 was written
// BEHAVIOUR
//  Reset: all shadow and display registers = 0; all outputs 0; wr_ready_o = 0 while reset_i is high, 1 on the first clk after release; blink counter = 0.
//  Write to addr k (0..8): shadow byte k <= data. After commit: dig(2k) = data[7:4], dig(2k+1) = data[3:0].
//  Write to addr 9: shadow ctrl <= data[2:0]. bit0 -> dato0, bit1 -> dato2, bit2 -> cron done.
//  Write to addr 10..14: data discarded, handshake completes, addr_err_o <= 1.
//  Write to addr 15: both sticky errors clear on the next clk; no shadow change.
//  BCD check on writes to 0..8: if either nibble > 9, bcd_err_o <= 1 and the byte is still stored as-is (the font renders 0x3A..0x3F glyphs).
//  Same-cycle clear and error: set wins.
//  Frame edge: vsync_i passes through SYNC_STAGES flops. A falling edge of the synchronised signal (1 -> 0) raises edge_q for one cycle.
//  FSM states:
//   IDLE  : wr_ready_o = 1, accepts writes. edge_q -> COMMIT.
//   COMMIT: one cycle. wr_ready_o = 0. display bank <= shadow bank. frame_tick_o = 1. Blink counter steps. -> IDLE.
//   A write presented during COMMIT stalls (is not lost) and is accepted in IDLE next cycle.
//   Because the stall is one cycle, that write appears on the next frame.
//  Latency: an accepted write appears at the outputs on the first commit after acceptance (<= 1 frame + SYNC_STAGES + 1 clk).
//  Blink: when committed cron done = 1, the counter counts commits 0..BLINK_FRAMES-1 and wraps; crontermino_o toggles on each wrap, first rising at the commit where done becomes 1.
//  When done = 0: counter = 0 and crontermino_o = 0, both forced at that commit.
//  Reset mid-frame: everything clears asynchronously. The first commit after release shows whatever was written since release; edge detector history is also cleared (no false edge from reset).
//  vsync_i held low through reset release: no commit until a new 1 -> 0 transition.
// TESTING
//  Reset, write addr0 = 8'h25, pulse vsync low -> dig0 = 2, dig1 = 5, frame_tick 1 clk, at SYNC_STAGES+1 clk after the edge.
//  Write addr4 = 8'h59 with no vsync edge -> dig8/dig9 stay 0; after the next edge -> 5/9.
//  Hold wr_valid on the COMMIT cycle (addr3 = 8'h12) -> ready low 1 clk, accepted next clk, visible on the following frame only.
//  Write addr9 = 8'h07, BLINK_FRAMES = 2, 6 frames -> dato0 = 8'h01, dato2 = 8'h01, crontermino pattern 1,1,0,0,1,1.
//  Write addr2 = 8'h3C and addr11 -> bcd_err = 1, addr_err = 1, dig5 = 4'hC after commit. Write addr15 -> both clear.
//  Assert reset_i mid-frame after writes -> all outputs 0 immediately; no frame_tick until the next vsync falling edge.

Source files
------------

// File: rtl/digit_frame_latch.sv
// rtl/digit_frame_latch.sv - frame-synchronous display data staging for the VGA time overlay
//
// Purpose:
//   Byte writes from the RTC/chronometer controller land in a shadow bank.
//   The shadow bank is copied to the display bank once per frame, on the
//   falling edge of the resynchronised vsync. This keeps the raster from ever
//   showing a half-updated time. The block also drives the ring blink request
//   and two sticky error flags.
//
// Ports:
//   clk               system clock
//   reset_i           asynchronous, active-high reset
//   vsync_i           vsync from vgasync, active low, asynchronous to clk
//   wr_valid_i        write request
//   wr_ready_o        write accepted on a clock where valid & ready
//   wr_addr_i[3:0]    0..8 BCD byte, 9 control, 10..14 invalid, 15 clear errors
//   wr_data_i[7:0]    write data
//   dig0_o..dig17_o   committed BCD nibbles; dig(2k) = byte k high nibble
//   dato0_o[7:0]      8'h01 selects the 12 h format
//   dato2_o[7:0]      8'h01 = AM, 8'h00 = PM
//   crontermino_o     blinking ring request
//   frame_tick_o      one-cycle pulse on each commit
//   bcd_err_o         sticky: a nibble above 9 was written
//   addr_err_o        sticky: an address in 10..14 was written

module digit_frame_latch #(
   parameter int BLINK_FRAMES = 30,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       reset_i,
   input  logic       vsync_i,
   input  logic       wr_valid_i,
   output logic       wr_ready_o,
   input  logic [3:0] wr_addr_i,
   input  logic [7:0] wr_data_i,
   output logic [3:0] dig0_o,
   output logic [3:0] dig1_o,
   output logic [3:0] dig2_o,
   output logic [3:0] dig3_o,
   output logic [3:0] dig4_o,
   output logic [3:0] dig5_o,
   output logic [3:0] dig6_o,
   output logic [3:0] dig7_o,
   output logic [3:0] dig8_o,
   output logic [3:0] dig9_o,
   output logic [3:0] dig10_o,
   output logic [3:0] dig11_o,
   output logic [3:0] dig12_o,
   output logic [3:0] dig13_o,
   output logic [3:0] dig14_o,
   output logic [3:0] dig15_o,
   output logic [3:0] dig16_o,
   output logic [3:0] dig17_o,
   output logic [7:0] dato0_o,
   output logic [7:0] dato2_o,
   output logic       crontermino_o,
   output logic       frame_tick_o,
   output logic       bcd_err_o,
   output logic       addr_err_o
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_COMMIT = 1'b1;
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

   logic [SYNC_STAGES-1:0] vs_sync_q;
   logic                   vs_hist_q;
   logic                   edge_q;
   logic [0:0]             state_q;
   logic                   ready_q;
   logic [7:0]             shadow_q [9];
   logic [7:0]             disp_q   [9];
   logic [2:0]             shadow_ctrl_q;
   logic [2:0]             disp_ctrl_q;
   logic [7:0]             blink_cnt_q;
   logic                   cron_q;
   logic                   bcd_err_q;
   logic                   addr_err_q;
   logic                   accept;
   logic                   data_bad;

   // Falling edge of the synchronised vsync. The history flop resets low,
   // so leaving reset can never look like a 1 -> 0 transition.
   assign edge_q   = vs_hist_q & ~vs_sync_q[SYNC_STAGES-1];

   // ready_q keeps the port closed while reset is held and opens it on the
   // first clock after release; COMMIT closes it for one cycle.
   assign wr_ready_o = ready_q & (state_q == ST_IDLE);
   assign accept     = wr_valid_i & wr_ready_o;
   assign data_bad   = (wr_data_i[7:4] > 4'd9) || (wr_data_i[3:0] > 4'd9);

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         vs_sync_q     <= '0;
         vs_hist_q     <= 1'b0;
         state_q       <= ST_IDLE;
         ready_q       <= 1'b0;
         shadow_ctrl_q <= 3'd0;
         disp_ctrl_q   <= 3'd0;
         blink_cnt_q   <= 8'd0;
         cron_q        <= 1'b0;
         bcd_err_q     <= 1'b0;
         addr_err_q    <= 1'b0;
         for (int k = 0; k < 9; k++) begin
            shadow_q[k] <= 8'd0;
            disp_q[k]   <= 8'd0;
         end
      end else begin
         vs_sync_q <= {vs_sync_q[SYNC_STAGES-2:0], vsync_i};
         vs_hist_q <= vs_sync_q[SYNC_STAGES-1];
         ready_q   <= 1'b1;

         case (state_q)
            ST_IDLE: begin
               if (edge_q) state_q <= ST_COMMIT;
            end
            default: begin
               state_q     <= ST_IDLE;
               disp_ctrl_q <= shadow_ctrl_q;
               for (int k = 0; k < 9; k++) disp_q[k] <= shadow_q[k];
               // Blink phase restarts with the ring lit on the commit where
               // done first appears; afterwards it toggles on every wrap.
               if (!shadow_ctrl_q[2]) begin
                  blink_cnt_q <= 8'd0;
                  cron_q      <= 1'b0;
               end else if (!disp_ctrl_q[2]) begin
                  blink_cnt_q <= 8'd0;
                  cron_q      <= 1'b1;
               end else if (blink_cnt_q == BLINK_LAST) begin
                  blink_cnt_q <= 8'd0;
                  cron_q      <= ~cron_q;
               end else begin
                  blink_cnt_q <= blink_cnt_q + 8'd1;
               end
            end
         endcase

         if (accept) begin
            // Clear first so a set in the same cycle wins.
            if (wr_addr_i == 4'd15) begin
               bcd_err_q  <= 1'b0;
               addr_err_q <= 1'b0;
            end
            if (wr_addr_i <= 4'd8) begin
               // Out-of-range nibbles are kept: the font has glyphs for them.
               for (int k = 0; k < 9; k++)
                  if (wr_addr_i == 4'(k)) shadow_q[k] <= wr_data_i;
               if (data_bad) bcd_err_q <= 1'b1;
            end
            if (wr_addr_i == 4'd9) shadow_ctrl_q <= wr_data_i[2:0];
            if ((wr_addr_i >= 4'd10) && (wr_addr_i <= 4'd14)) addr_err_q <= 1'b1;
         end
      end
   end

   assign frame_tick_o  = (state_q == ST_COMMIT);
   assign crontermino_o = cron_q;
   assign bcd_err_o     = bcd_err_q;
   assign addr_err_o    = addr_err_q;
   assign dato0_o       = {7'd0, disp_ctrl_q[0]};
   assign dato2_o       = {7'd0, disp_ctrl_q[1]};

   assign dig0_o  = disp_q[0][7:4];
   assign dig1_o  = disp_q[0][3:0];
   assign dig2_o  = disp_q[1][7:4];
   assign dig3_o  = disp_q[1][3:0];
   assign dig4_o  = disp_q[2][7:4];
   assign dig5_o  = disp_q[2][3:0];
   assign dig6_o  = disp_q[3][7:4];
   assign dig7_o  = disp_q[3][3:0];
   assign dig8_o  = disp_q[4][7:4];
   assign dig9_o  = disp_q[4][3:0];
   assign dig10_o = disp_q[5][7:4];
   assign dig11_o = disp_q[5][3:0];
   assign dig12_o = disp_q[6][7:4];
   assign dig13_o = disp_q[6][3:0];
   assign dig14_o = disp_q[7][7:4];
   assign dig15_o = disp_q[7][3:0];
   assign dig16_o = disp_q[8][7:4];
   assign dig17_o = disp_q[8][3:0];

endmodule

// File: tb/tb_digit_frame_latch.sv
// tb/tb_digit_frame_latch.sv - self-checking bench for digit_frame_latch

module tb_digit_frame_latch;

   localparam int BF = 2;
   localparam int S  = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vsync = 1'b1;
   logic       valid = 1'b0;
   logic [3:0] addr = 4'd0;
   logic [7:0] data = 8'd0;
   logic       wr_ready;
   logic [3:0] dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7, dig8;
   logic [3:0] dig9, dig10, dig11, dig12, dig13, dig14, dig15, dig16, dig17;
   logic [7:0] dato0, dato2;
   logic       cron, tick, bcd_err, addr_err;

   digit_frame_latch #(.BLINK_FRAMES(BF), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset_i(rst), .vsync_i(vsync),
      .wr_valid_i(valid), .wr_ready_o(wr_ready), .wr_addr_i(addr), .wr_data_i(data),
      .dig0_o(dig0), .dig1_o(dig1), .dig2_o(dig2), .dig3_o(dig3), .dig4_o(dig4),
      .dig5_o(dig5), .dig6_o(dig6), .dig7_o(dig7), .dig8_o(dig8), .dig9_o(dig9),
      .dig10_o(dig10), .dig11_o(dig11), .dig12_o(dig12), .dig13_o(dig13),
      .dig14_o(dig14), .dig15_o(dig15), .dig16_o(dig16), .dig17_o(dig17),
      .dato0_o(dato0), .dato2_o(dato2), .crontermino_o(cron), .frame_tick_o(tick),
      .bcd_err_o(bcd_err), .addr_err_o(addr_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_ticks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: bytes, committed bytes, commit countdown, blink phase.
   logic [7:0] m_sh [9];
   logic [7:0] m_disp [9];
   logic [2:0] m_ctrl, m_dctrl;
   bit         m_bcd, m_aerr, m_cron, m_tick, m_rdy, m_vprev;
   int         m_n, m_cd;

   task automatic model_reset();
      for (int i = 0; i < 9; i++) begin
         m_sh[i] = 8'd0;
         m_disp[i] = 8'd0;
      end
      m_ctrl = 3'd0; m_dctrl = 3'd0;
      m_bcd = 0; m_aerr = 0; m_cron = 0; m_tick = 0; m_rdy = 0; m_vprev = 0;
      m_n = 0; m_cd = 0;
   endtask

   // Advance the model across the coming rising edge, using the inputs that
   // the DUT will sample there.
   task automatic model_step();
      bit cur_ready;
      bit new_tick;
      if (rst) begin
         model_reset();
         return;
      end
      cur_ready = m_rdy && !m_tick;
      if (m_tick) begin
         for (int i = 0; i < 9; i++) m_disp[i] = m_sh[i];
         if (m_ctrl[2]) begin
            if (!m_dctrl[2]) m_n = 0;
            else m_n = m_n + 1;
            m_cron = ((m_n / BF) % 2) == 0;
         end else begin
            m_n = 0;
            m_cron = 0;
         end
         m_dctrl = m_ctrl;
      end
      if (valid && cur_ready) begin
         if (addr <= 4'd8) begin
            m_sh[addr] = data;
            if (data[7:4] > 4'd9 || data[3:0] > 4'd9) m_bcd = 1;
         end else if (addr == 4'd9) m_ctrl = data[2:0];
         else if (addr == 4'd15) begin
            m_bcd = 0; m_aerr = 0;
         end else m_aerr = 1;
      end
      new_tick = (m_cd == 1);
      if (m_cd > 0) m_cd = m_cd - 1;
      if (m_vprev && !vsync) m_cd = S;
      m_vprev = vsync;
      m_tick = new_tick;
      m_rdy = 1;
   endtask

   function automatic logic [92:0] exp_vec();
      logic [71:0] d;
      for (int i = 0; i < 9; i++) d[71-8*i -: 8] = m_disp[i];
      return {d, 7'd0, m_dctrl[0], 7'd0, m_dctrl[1], m_cron, m_tick, m_bcd, m_aerr,
              m_rdy && !m_tick};
   endfunction

   logic [92:0] dut_vec;
   assign dut_vec = {dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7, dig8, dig9,
                     dig10, dig11, dig12, dig13, dig14, dig15, dig16, dig17,
                     dato0, dato2, cron, tick, bcd_err, addr_err, wr_ready};

   always @(negedge clk) begin
      logic [92:0] e;
      if (rst) model_reset();
      e = exp_vec();
      checks++;
      if (dut_vec !== e) begin
         errors++;
         $display("FAIL cycle_compare t=%0t: dut=%h model=%h", $time, dut_vec, e);
      end
      if (tick) n_ticks++;
      model_step();
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      bit done;
      done = 0;
      valid = 1; addr = a; data = d;
      for (int i = 0; i < 20 && !done; i++) begin
         done = wr_ready;
         step(1);
      end
      valid = 0;
      chk("wr_accept", 32'(done), 32'd1);
   endtask

   task automatic frame();
      vsync = 0;
      step(4);
      vsync = 1;
      step(6);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [5:0] pat;
      int t0;
      pat = 6'b110011;
      model_reset();

      // Reset state
      step(3);
      chk("reset_ready", 32'(wr_ready), 32'd0);
      chk("reset_dig0", 32'(dig0), 32'd0);
      chk("reset_tick", 32'(tick), 32'd0);
      rst = 0;
      step(1);
      chk("ready_after_release", 32'(wr_ready), 32'd1);

      // First commit timing
      wr(4'd0, 8'h25);
      vsync = 0;
      step(2);
      chk("tick_early", 32'(tick), 32'd0);
      step(1);
      chk("tick_pulse", 32'(tick), 32'd1);
      chk("dig0_before_commit", 32'(dig0), 32'd0);
      step(1);
      chk("tick_single", 32'(tick), 32'd0);
      chk("dig0", 32'(dig0), 32'd2);
      chk("dig1", 32'(dig1), 32'd5);
      step(2);
      vsync = 1;
      step(6);

      // No commit without an edge
      wr(4'd4, 8'h59);
      step(3);
      chk("dig8_pending", 32'(dig8), 32'd0);
      chk("dig9_pending", 32'(dig9), 32'd0);
      frame();
      chk("dig8", 32'(dig8), 32'd5);
      chk("dig9", 32'(dig9), 32'd9);

      // Write stalled by COMMIT lands on the following frame
      vsync = 0;
      step(3);
      chk("commit_tick", 32'(tick), 32'd1);
      chk("commit_ready_low", 32'(wr_ready), 32'd0);
      valid = 1; addr = 4'd3; data = 8'h12;
      step(1);
      chk("ready_after_commit", 32'(wr_ready), 32'd1);
      step(1);
      valid = 0;
      chk("dig6_not_yet", 32'(dig6), 32'd0);
      step(1);
      vsync = 1;
      step(6);
      chk("dig7_not_yet", 32'(dig7), 32'd0);
      frame();
      chk("dig6", 32'(dig6), 32'd1);
      chk("dig7", 32'(dig7), 32'd2);

      // Control and blink
      wr(4'd9, 8'h07);
      for (int f = 0; f < 6; f++) begin
         frame();
         chk($sformatf("cron_frame%0d", f), 32'(cron), 32'(pat[5-f]));
         if (f == 0) begin
            chk("dato0", 32'(dato0), 32'h01);
            chk("dato2", 32'(dato2), 32'h01);
         end
      end

      // Error flags
      wr(4'd2, 8'h3C);
      chk("bcd_err_set", 32'(bcd_err), 32'd1);
      chk("addr_err_clear", 32'(addr_err), 32'd0);
      wr(4'd11, 8'h00);
      chk("addr_err_set", 32'(addr_err), 32'd1);
      frame();
      chk("dig4", 32'(dig4), 32'd3);
      chk("dig5", 32'(dig5), 32'hC);
      wr(4'd15, 8'h00);
      chk("bcd_err_cleared", 32'(bcd_err), 32'd0);
      chk("addr_err_cleared", 32'(addr_err), 32'd0);

      // Done removed
      wr(4'd9, 8'h00);
      frame();
      chk("cron_off", 32'(cron), 32'd0);
      chk("dato0_off", 32'(dato0), 32'h00);

      // Reset mid-frame
      wr(4'd1, 8'h47);
      wr(4'd2, 8'hAA);
      step(2);
      rst = 1;
      #1;
      chk("rst_dig0", 32'(dig0), 32'd0);
      chk("rst_dig8", 32'(dig8), 32'd0);
      chk("rst_bcd", 32'(bcd_err), 32'd0);
      chk("rst_ready", 32'(wr_ready), 32'd0);
      step(3);
      rst = 0;
      t0 = n_ticks;
      step(20);
      chk("no_tick_after_reset", 32'(n_ticks - t0), 32'd0);

      // vsync held low across release
      rst = 1;
      vsync = 0;
      step(2);
      rst = 0;
      t0 = n_ticks;
      step(20);
      chk("no_tick_vsync_low", 32'(n_ticks - t0), 32'd0);
      vsync = 1;
      step(5);
      wr(4'd0, 8'h11);
      frame();
      chk("tick_after_new_edge", 32'(n_ticks - t0), 32'd1);
      chk("post_rst_dig0", 32'(dig0), 32'd1);
      chk("post_rst_dig1", 32'(dig1), 32'd1);
      chk("post_rst_dig2", 32'(dig2), 32'd0);
      chk("post_rst_dig3", 32'(dig3), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
